// File: rtl/mesa_pkg.sv
// Shared definitions for the MESA Ro-path blocks: report FSM state
// encodings, default header constants and payload counter sizing.
package mesa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEFER   = 2'd1,
        HDR     = 2'd2,
        PAYLOAD = 2'd3
    } rpt_state_t;

    localparam logic [7:0] MESA_PREAMBLE   = 8'hF0;
    localparam logic [7:0] MESA_RO_SLOT    = 8'hFE;
    localparam logic [7:0] MESA_RO_SUBSLOT = 8'h00;

    // Largest payload: 16 info words plus the optional timestamp word.
    localparam int unsigned MESA_MAX_WORDS = 16;
    localparam int unsigned MESA_MAX_PAY   = 4 * MESA_MAX_WORDS + 4;
    localparam int unsigned MESA_PAY_CNT_W = $clog2(MESA_MAX_PAY);

endpackage

// File: rtl/mesa_info_rpt_time_stamp.sv
// Build timestamp source. Only instantiated by mesa_info_rpt when
// MESA_INFO_TIMESTAMP_EN is defined; the value is fixed at build time.
module time_stamp #(
    parameter logic [31:0] BUILD_STAMP = 32'h2024_0611
) (
    output logic [31:0] time_dout
);

    assign time_dout = BUILD_STAMP;

endmodule

// File: rtl/mesa_info_rpt.sv
// mesa_info_rpt: injects an info report packet (4-byte header plus
// NUM_WORDS info words) into the Ro byte stream, deferring to any core
// packet in flight. Define MESA_INFO_TIMESTAMP_EN to append the build
// timestamp word after the info words.
module mesa_info_rpt
    import mesa_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 3,
    parameter logic [7:0]  PREAMBLE   = MESA_PREAMBLE,
    parameter logic [7:0]  RO_SLOT    = MESA_RO_SLOT,
    parameter logic [7:0]  RO_SUBSLOT = MESA_RO_SUBSLOT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   report_req,
    input  logic [32*NUM_WORDS-1:0] info_words,
    input  logic [7:0]             mesa_core_ro_byte_d,
    input  logic                   mesa_core_ro_byte_en,
    input  logic                   mesa_core_ro_done,
    input  logic                   mesa_ro_busy,
    output logic [7:0]             mesa_ro_byte_d,
    output logic                   mesa_ro_byte_en,
    output logic                   mesa_ro_done,
    output logic                   report_active,
    output logic                   drop_err
);

`ifdef MESA_INFO_TIMESTAMP_EN
    localparam int unsigned TS_BYTES = 4;
`else
    localparam int unsigned TS_BYTES = 0;
`endif
    localparam int unsigned PAY_LEN   = 4 * NUM_WORDS + TS_BYTES;
    localparam int unsigned PAY_W     = 8 * PAY_LEN;
    localparam int unsigned PAY_CNT_W = MESA_PAY_CNT_W;
    localparam logic [7:0]  LEN       = 8'(PAY_LEN);

    rpt_state_t             state, state_nxt;
    logic [1:0]             hdr_idx, hdr_idx_nxt;
    logic [PAY_CNT_W-1:0]   pay_cnt, pay_cnt_nxt;
    logic                   pending, pending_nxt;
    logic                   pkt_open, pkt_open_nxt;
    logic                   kick, kick_nxt;
    logic                   busy_q;
    logic                   emit;
    logic                   drop_nxt;
    logic [32*NUM_WORDS-1:0] snap, snap_nxt;
    logic [PAY_W-1:0]       pay_vec;
    logic [7:0]             byte_nxt;
    logic                   en_nxt, done_nxt;

`ifdef MESA_INFO_TIMESTAMP_EN
    logic [31:0] ts_word;

    time_stamp u_time_stamp (
        .time_dout (ts_word)
    );

    assign pay_vec = {ts_word, snap};
`else
    assign pay_vec = snap;
`endif

    // Word k occupies bits [32k+31:32k]; bytes leave MSB first.
    function automatic logic [7:0] pay_byte(input logic [PAY_W-1:0] v,
                                            input logic [PAY_CNT_W-1:0] idx);
        logic [PAY_W-1:0] sh;
        int unsigned      off;
        off = 32 * (int'(idx) / 4) + 8 * (3 - (int'(idx) % 4));
        sh  = v >> off;
        return sh[7:0];
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return PREAMBLE;
            2'd1:    return RO_SLOT;
            2'd2:    return RO_SUBSLOT;
            default: return LEN;
        endcase
    endfunction

    assign report_active = (state == HDR) || (state == PAYLOAD);

    // Next-state, snapshot and muxed Ro byte selection.
    always_comb begin
        state_nxt    = state;
        hdr_idx_nxt  = hdr_idx;
        pay_cnt_nxt  = pay_cnt;
        pending_nxt  = pending;
        snap_nxt     = snap;
        kick_nxt     = 1'b0;
        drop_nxt     = drop_err;
        byte_nxt     = '0;
        en_nxt       = 1'b0;
        done_nxt     = 1'b0;
        pkt_open_nxt = mesa_core_ro_done ? 1'b0 :
                       (mesa_core_ro_byte_en ? 1'b1 : pkt_open);
        // First header byte is self-started; every later byte waits for
        // the serializer to finish the previous one.
        emit         = kick | (busy_q & ~mesa_ro_busy);

        unique case (state)
            IDLE: begin
                byte_nxt = mesa_core_ro_byte_d;
                en_nxt   = mesa_core_ro_byte_en;
                done_nxt = mesa_core_ro_done;
                if (report_req || pending) begin
                    pending_nxt = 1'b0;
                    // A done arriving now closes the packet, so no deferral.
                    if ((pkt_open || mesa_core_ro_byte_en) && !mesa_core_ro_done) begin
                        state_nxt = DEFER;
                    end else begin
                        state_nxt   = HDR;
                        snap_nxt    = info_words;
                        kick_nxt    = 1'b1;
                        hdr_idx_nxt = '0;
                    end
                end
            end
            DEFER: begin
                byte_nxt = mesa_core_ro_byte_d;
                en_nxt   = mesa_core_ro_byte_en;
                done_nxt = mesa_core_ro_done;
                if (report_req) pending_nxt = 1'b1;
                if (mesa_core_ro_done) begin
                    state_nxt   = HDR;
                    snap_nxt    = info_words;
                    kick_nxt    = 1'b1;
                    hdr_idx_nxt = '0;
                end
            end
            HDR: begin
                if (report_req) pending_nxt = 1'b1;
                if (mesa_core_ro_byte_en || mesa_core_ro_done) drop_nxt = 1'b1;
                if (emit) begin
                    byte_nxt = hdr_byte(hdr_idx);
                    en_nxt   = 1'b1;
                    if (hdr_idx == 2'd3) begin
                        state_nxt   = PAYLOAD;
                        hdr_idx_nxt = '0;
                        pay_cnt_nxt = '0;
                    end else begin
                        hdr_idx_nxt = hdr_idx + 2'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (report_req) pending_nxt = 1'b1;
                if (mesa_core_ro_byte_en || mesa_core_ro_done) drop_nxt = 1'b1;
                if (emit) begin
                    byte_nxt = pay_byte(pay_vec, pay_cnt);
                    en_nxt   = 1'b1;
                    if (pay_cnt == PAY_CNT_W'(PAY_LEN - 1)) begin
                        done_nxt    = 1'b1;
                        state_nxt   = IDLE;
                        pay_cnt_nxt = '0;
                    end else begin
                        pay_cnt_nxt = pay_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, snapshot and registered Ro outputs; reset abandons any report.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            hdr_idx         <= '0;
            pay_cnt         <= '0;
            pending         <= 1'b0;
            pkt_open        <= 1'b0;
            kick            <= 1'b0;
            busy_q          <= 1'b0;
            snap            <= '0;
            mesa_ro_byte_d  <= '0;
            mesa_ro_byte_en <= 1'b0;
            mesa_ro_done    <= 1'b0;
            drop_err        <= 1'b0;
        end else begin
            state           <= state_nxt;
            hdr_idx         <= hdr_idx_nxt;
            pay_cnt         <= pay_cnt_nxt;
            pending         <= pending_nxt;
            pkt_open        <= pkt_open_nxt;
            kick            <= kick_nxt;
            busy_q          <= mesa_ro_busy;
            snap            <= snap_nxt;
            mesa_ro_byte_d  <= byte_nxt;
            mesa_ro_byte_en <= en_nxt;
            mesa_ro_done    <= done_nxt;
            drop_err        <= drop_nxt;
        end
    end

endmodule

// File: doc/mesa_info_rpt.md
MESA_INFO_RPT -- requirements
Module: mesa_info_rpt

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 3, number of 32-bit info words reported (legal 1..16).
REQ-002 SHALL have parameter PREAMBLE, default 8'hF0, first header byte.
REQ-003 SHALL have parameter RO_SLOT, default 8'hFE, second header byte.
REQ-004 SHALL have parameter RO_SUBSLOT, default 8'h00, third header byte.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port report_req  input  1  single-cycle request to send the info report.
REQ-008 SHALL have port info_words  input  32*NUM_WORDS  info payload; word 0 in bits [31:0], sent first, MSB byte first.
REQ-009 SHALL have ports mesa_core_ro_byte_d / _en / _done  input  8/1/1  normal Ro byte path.
REQ-010 SHALL have port mesa_ro_busy  input  1  downstream serializer busy.
REQ-011 SHALL have ports mesa_ro_byte_d / _en / _done  output  8/1/1  muxed Ro byte path.
REQ-012 SHALL have port report_active  output  1  high while the FSM owns the Ro path.
REQ-013 SHALL have port drop_err  output  1  sticky: a core byte was discarded during a report.

Function
REQ-014 SHALL in IDLE pass the core path through with one register stage (1-cycle latency).
REQ-015 SHALL track core_pkt_open: set on core byte_en, cleared on core done.
REQ-016 SHALL on report_req in IDLE go to DEFER if core_pkt_open (or core byte_en same cycle), else to HDR.
REQ-017 SHALL leave DEFER for HDR the cycle after core done is passed through; core bytes pass unmodified in DEFER.
REQ-018 SHALL latch one pending request if report_req arrives outside IDLE; a second report starts on return to IDLE; further requests while pending are merged.
REQ-019 SHALL emit the first HDR byte the cycle after entering HDR; each later byte one cycle after a mesa_ro_busy falling edge (registered busy 1, current busy 0).
REQ-020 SHALL send header PREAMBLE, RO_SLOT, RO_SUBSLOT, LEN where LEN = 4*NUM_WORDS (+4 with timestamp), 8 bits.
REQ-021 SHALL in PAYLOAD use a byte counter, width clog2 of max payload, wrapping to 0 only on DONE.
REQ-022 SHALL sample info_words once, on the cycle HDR is entered; payload is that snapshot.
REQ-023 SHALL assert mesa_ro_done together with byte_en on the last payload byte, then go to IDLE.
REQ-024 SHALL hold mesa_ro_byte_en/done low in HDR/PAYLOAD except on emitted bytes.
REQ-025 SHALL discard core byte_en/done in HDR/PAYLOAD and set drop_err; drop_err clears only on reset.
REQ-026 SHALL drive report_active high in HDR and PAYLOAD, low otherwise.

Reset
REQ-027 SHALL on reset_n low asynchronously force IDLE, counter 0, pending 0, core_pkt_open 0, snapshot 0, all outputs 0.
REQ-028 SHALL abandon a report in progress on reset without emitting done; after release, first action needs a new request.

Configuration
REQ-029 SHALL with MESA_INFO_TIMESTAMP_EN defined append the 32-bit build timestamp (time_stamp instance) after the info words, MSB first, LEN += 4.
REQ-030 SHALL without MESA_INFO_TIMESTAMP_EN omit the timestamp word and the time_stamp instance.

Structure
REQ-031 SHALL take FSM state encodings (IDLE, DEFER, HDR, PAYLOAD) and the default header constants from shared package mesa_pkg.
REQ-032 SHALL instantiate sub-module time_stamp only when MESA_INFO_TIMESTAMP_EN is defined; no other sub-modules.

Verification
REQ-033 SHALL cover: NUM_WORDS=3, no timestamp, info_words={32'h33333333,32'h22222222,32'h11111111}, req, busy pulse after each byte -> F0 FE 00 0C 11 11 11 11 22..22 33..33, done on 16th byte.
REQ-034 SHALL cover: req while core packet open -> core bytes and core done pass through, header F0 starts the cycle after done passes.
REQ-035 SHALL cover: core byte_en during PAYLOAD -> byte not output, drop_err=1 and stays 1.
REQ-036 SHALL cover: two reqs during active report -> exactly one extra report follows, total 2.
REQ-037 SHALL cover: reset_n low after 5th byte -> outputs 0 asynchronously, no done; next req gives full report from F0.
REQ-038 SHALL cover: MESA_INFO_TIMESTAMP_EN, NUM_WORDS=1 -> LEN 8'h08, 8 payload bytes, last 4 equal time_stamp output.
